// File: rtl/aes_pkg.sv
// Shared AES constants, sequencer state encoding and round-key slicing helper.
package aes_pkg;

    localparam int unsigned AES_BLK_W = 128;
    localparam int unsigned NR_AES128 = 10;
    localparam int unsigned NR_AES192 = 12;
    localparam int unsigned NR_AES256 = 14;
    localparam int unsigned KW_MAX    = AES_BLK_W * (NR_AES256 + 1);
    localparam int unsigned KW_IW     = $clog2(KW_MAX);

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} seq_state_e;

    // Slice r of a zero-extended round-key bus; indices past the largest key schedule give zero.
    function automatic logic [AES_BLK_W-1:0] round_key(input logic [KW_MAX-1:0] w,
                                                       input int unsigned r);
        logic [AES_BLK_W-1:0] key;
        logic [KW_IW-1:0]     base;
        key  = '0;
        base = KW_IW'(AES_BLK_W * r);
        if (r <= NR_AES256) begin
            key = w[base +: AES_BLK_W];
        end
        return key;
    endfunction

endpackage

// File: rtl/aes_dec_key_sel.sv
// Combinational round-indexed key mux over a flat round-key bus.
module aes_dec_key_sel
    import aes_pkg::*;
#(
    parameter int unsigned NR = NR_AES128,
    parameter int unsigned KW = AES_BLK_W * (NR + 1),
    parameter int unsigned RW = $clog2(NR + 1)
) (
    input  logic [KW-1:0]        w,
    input  logic [RW-1:0]        round,
    output logic [AES_BLK_W-1:0] key_c
);

    always_comb begin
        key_c = '0;
        if (32'(round) <= NR) begin
            key_c = round_key(KW_MAX'(w), 32'(round));
        end
    end

endmodule

// File: rtl/aes_dec_sched.sv
// Iterative AES inverse-cipher sequencer: one round per clock through an external
// round datapath, valid/ready on both sides.
module aes_dec_sched
    import aes_pkg::*;
#(
    parameter  int unsigned NR = NR_AES128,
    parameter  int unsigned KW = AES_BLK_W * (NR + 1),
    localparam int unsigned RW = $clog2(NR + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [AES_BLK_W-1:0] in_data,
    input  logic [KW-1:0]        w,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [AES_BLK_W-1:0] out_data,
    output logic                 busy,
    output logic [RW-1:0]        round,
    output logic [AES_BLK_W-1:0] dp_state,
    output logic [AES_BLK_W-1:0] dp_key,
    input  logic [AES_BLK_W-1:0] dp_mid_in,
    input  logic [AES_BLK_W-1:0] dp_final_in
);

    seq_state_e           fsm_q, fsm_d;
    logic [AES_BLK_W-1:0] st_q, st_d;
    logic [RW-1:0]        round_q, round_d;
    logic                 out_valid_q, out_valid_d;
    logic                 busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q       <= IDLE;
            st_q        <= '0;
            round_q     <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            st_q        <= st_d;
            round_q     <= round_d;
            out_valid_q <= out_valid_d;
            busy_q      <= (fsm_d != IDLE);
        end
    end

    // Initial AddRoundKey on accept, NR-1 middle rounds, one final round, then hold for the consumer.
    always_comb begin
        fsm_d       = fsm_q;
        st_d        = st_q;
        round_d     = round_q;
        out_valid_d = out_valid_q;
        case (fsm_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    st_d    = in_data ^ w[AES_BLK_W-1:0];
                    round_d = RW'(1);
                    fsm_d   = ROUND;
                end
            end
            ROUND: begin
                st_d    = dp_mid_in;
                round_d = round_q + RW'(1);
                if (round_q == RW'(NR - 1)) begin
                    fsm_d = FINAL;
                end
            end
            FINAL: begin
                st_d        = dp_final_in;
                out_valid_d = 1'b1;
                fsm_d       = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    round_d     = '0;
                    fsm_d       = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    assign in_ready  = (fsm_q == IDLE) && !rst;
    assign out_valid = out_valid_q;
    assign out_data  = st_q;
    assign dp_state  = st_q;
    assign round     = round_q;
    assign busy      = busy_q;

    aes_dec_key_sel #(
        .NR(NR),
        .KW(KW),
        .RW(RW)
    ) u_key_sel (
        .w    (w),
        .round(round_q),
        .key_c(dp_key)
    );

endmodule

// File: tb/tb_aes_dec_sched.sv
// Bench for aes_dec_sched: AES-128 and AES-256 sequencers driving a behavioural
// inverse-round datapath, checked against FIPS-197 known-answer vectors.
module tb_aes_dec_sched;

    localparam int unsigned NR_A = 10;
    localparam int unsigned NR_B = 14;
    localparam int unsigned KW_A = 128 * (NR_A + 1);
    localparam int unsigned KW_B = 128 * (NR_B + 1);

    localparam logic [127:0] PT_REF  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_C3   = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] KEY_C1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [255:0] KEY_C3  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] KEY_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B    = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B    = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_ZERO = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic clk = 1'b0;
    logic rst;

    logic            iv_a, ir_a, ov_a, or_a, busy_a;
    logic [127:0]    id_a, od_a, dps_a, dpk_a, mid_a, fin_a;
    logic [3:0]      rnd_a;
    logic [KW_A-1:0] w_a;

    logic            iv_b, ir_b, ov_b, or_b, busy_b;
    logic [127:0]    id_b, od_b, dps_b, dpk_b, mid_b, fin_b;
    logic [3:0]      rnd_b;
    logic [KW_B-1:0] w_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    aes_dec_sched #(.NR(NR_A)) u_dut_a (
        .clk(clk), .rst(rst),
        .in_valid(iv_a), .in_ready(ir_a), .in_data(id_a), .w(w_a),
        .out_valid(ov_a), .out_ready(or_a), .out_data(od_a),
        .busy(busy_a), .round(rnd_a),
        .dp_state(dps_a), .dp_key(dpk_a), .dp_mid_in(mid_a), .dp_final_in(fin_a)
    );

    aes_dec_sched #(.NR(NR_B)) u_dut_b (
        .clk(clk), .rst(rst),
        .in_valid(iv_b), .in_ready(ir_b), .in_data(id_b), .w(w_b),
        .out_valid(ov_b), .out_ready(or_b), .out_data(od_b),
        .busy(busy_b), .round(rnd_b),
        .dp_state(dps_b), .dp_key(dpk_b), .dp_mid_in(mid_b), .dp_final_in(fin_b)
    );

    // ---------------- GF(2^8) and AES round model ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse (and maps 0 to 0).
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r;
        r = a;
        for (int i = 0; i < 6; i++) r = gmul(gmul(r, r), a);
        return gmul(r, r);
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return 8'((x << n) | (x >> (8 - n)));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] x;
        x = ginv(b);
        return x ^ rotl8(x, 1) ^ rotl8(x, 2) ^ rotl8(x, 3) ^ rotl8(x, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return ginv(rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05);
    endfunction

    function automatic logic [127:0] dec_final(input logic [127:0] s, input logic [127:0] k);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(r+4*c) -: 8] = inv_sbox(s[127-8*(r+4*((c-r+4)%4)) -: 8]);
            end
        end
        return o ^ k;
    endfunction

    function automatic logic [127:0] dec_mid(input logic [127:0] s, input logic [127:0] k);
        logic [127:0] t;
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        t = dec_final(s, k);
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = t[127-32*c -: 8];
            a1 = t[119-32*c -: 8];
            a2 = t[111-32*c -: 8];
            a3 = t[103-32*c -: 8];
            o[127-32*c -: 8] = gmul(a0,8'h0e) ^ gmul(a1,8'h0b) ^ gmul(a2,8'h0d) ^ gmul(a3,8'h09);
            o[119-32*c -: 8] = gmul(a0,8'h09) ^ gmul(a1,8'h0e) ^ gmul(a2,8'h0b) ^ gmul(a3,8'h0d);
            o[111-32*c -: 8] = gmul(a0,8'h0d) ^ gmul(a1,8'h09) ^ gmul(a2,8'h0e) ^ gmul(a3,8'h0b);
            o[103-32*c -: 8] = gmul(a0,8'h0b) ^ gmul(a1,8'h0d) ^ gmul(a2,8'h09) ^ gmul(a3,8'h0e);
        end
        return o;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    endfunction

    // Key expansion; returns round keys reversed so slice 0 is the last encrypt key.
    function automatic logic [1919:0] dec_keys(input logic [255:0] key, input int nk);
        logic [31:0]   wd [60];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1919:0] bus;
        int            nr;
        nr  = nk + 6;
        rc  = 8'h01;
        bus = '0;
        for (int i = 0; i < 60; i++) wd[i] = 32'h0;
        for (int i = 0; i < nk; i++) wd[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = wd[i-1];
            if (i % nk == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            wd[i] = wd[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) begin
            bus[128*(nr-r) +: 128] = {wd[4*r], wd[4*r+1], wd[4*r+2], wd[4*r+3]};
        end
        return bus;
    endfunction

    // External round datapath for both sequencers.
    always_comb begin
        mid_a = dec_mid(dps_a, dpk_a);
        fin_a = dec_final(dps_a, dpk_a);
        mid_b = dec_mid(dps_b, dpk_b);
        fin_b = dec_final(dps_b, dpk_b);
    end

    // ---------------- bench helpers ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic get_ov(input bit sel);
        return sel ? ov_b : ov_a;
    endfunction
    function automatic logic get_ir(input bit sel);
        return sel ? ir_b : ir_a;
    endfunction
    function automatic logic get_busy(input bit sel);
        return sel ? busy_b : busy_a;
    endfunction
    function automatic logic [127:0] get_od(input bit sel);
        return sel ? od_b : od_a;
    endfunction
    function automatic logic [3:0] get_rnd(input bit sel);
        return sel ? rnd_b : rnd_a;
    endfunction

    task automatic set_in(input bit sel, input logic v, input logic [127:0] d);
        if (sel) begin
            iv_b = v;
            id_b = d;
        end else begin
            iv_a = v;
            id_a = d;
        end
    endtask

    // One block with out_ready held high: latency, result and return to idle.
    task automatic run_block(input bit sel, input logic [127:0] ct, input logic [127:0] pt,
                             input int nr, input string tag);
        int k;
        @(negedge clk);
        chk({tag, " in_ready idle"}, 128'(get_ir(sel)), 128'd1);
        set_in(sel, 1'b1, ct);
        @(negedge clk);
        set_in(sel, 1'b0, '0);
        chk({tag, " busy after accept"}, 128'(get_busy(sel)), 128'd1);
        chk({tag, " round after accept"}, 128'(get_rnd(sel)), 128'd1);
        k = 0;
        while (!get_ov(sel) && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk({tag, " latency"}, 128'(k), 128'(nr));
        chk({tag, " plaintext"}, get_od(sel), pt);
        chk({tag, " round at done"}, 128'(get_rnd(sel)), 128'(nr));
        @(negedge clk);
        chk({tag, " out_valid cleared"}, 128'(get_ov(sel)), 128'd0);
        chk({tag, " in_ready back"}, 128'(get_ir(sel)), 128'd1);
    endtask

    typedef struct {
        string        name;
        bit           sel;
        logic [255:0] key;
        int           nk;
        logic [127:0] ct;
        logic [127:0] pt;
    } vec_t;

    vec_t vecs[4];

    initial begin
        logic [1919:0] kb;
        logic [1919:0] kb_c1;
        logic [127:0]  outs[2];
        int            acc_t[2];
        int            nacc, nout, k, extra;

        vecs[0] = '{"c1_aes128",   1'b0, {KEY_C1, 128'h0}, 4, CT_C1,   PT_REF};
        vecs[1] = '{"b_aes128",    1'b0, {KEY_B,  128'h0}, 4, CT_B,    PT_B};
        vecs[2] = '{"zero_aes128", 1'b0, 256'h0,           4, CT_ZERO, 128'h0};
        vecs[3] = '{"c3_aes256",   1'b1, KEY_C3,           8, CT_C3,   PT_REF};

        kb_c1 = dec_keys({KEY_C1, 128'h0}, 4);
        rst  = 1'b1;
        iv_a = 1'b0; id_a = '0; or_a = 1'b1; w_a = kb_c1[KW_A-1:0];
        iv_b = 1'b0; id_b = '0; or_b = 1'b1; w_b = '0;

        repeat (2) @(negedge clk);
        chk("in_ready low in reset", 128'(ir_a), 128'd0);
        rst = 1'b0;
        #1;
        chk("reset in_ready a",  128'(ir_a),   128'd1);
        chk("reset out_valid a", 128'(ov_a),   128'd0);
        chk("reset busy a",      128'(busy_a), 128'd0);
        chk("reset round a",     128'(rnd_a),  128'd0);
        chk("reset state a",     od_a,         128'd0);
        chk("reset in_ready b",  128'(ir_b),   128'd1);
        chk("reset busy b",      128'(busy_b), 128'd0);
        chk("reset round b",     128'(rnd_b),  128'd0);

        // Known-answer vectors on both key sizes.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            kb = dec_keys(vecs[i].key, vecs[i].nk);
            if (vecs[i].sel) w_b = kb;
            else             w_a = kb[KW_A-1:0];
            run_block(vecs[i].sel, vecs[i].ct, vecs[i].pt, vecs[i].sel ? NR_B : NR_A, vecs[i].name);
        end

        w_a = kb_c1[KW_A-1:0];

        // Back-pressure: result held while out_ready is low.
        or_a = 1'b0;
        @(negedge clk);
        iv_a = 1'b1; id_a = CT_C1;
        @(negedge clk);
        iv_a = 1'b0;
        k = 0;
        while (!ov_a && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("bp latency", 128'(k), 128'(NR_A));
        for (int i = 0; i < 5; i++) begin
            chk("bp out_valid held", 128'(ov_a),   128'd1);
            chk("bp out_data held",  od_a,         PT_REF);
            chk("bp in_ready low",   128'(ir_a),   128'd0);
            chk("bp busy high",      128'(busy_a), 128'd1);
            @(negedge clk);
        end
        or_a = 1'b1;
        @(negedge clk);
        chk("bp release out_valid", 128'(ov_a),  128'd0);
        chk("bp release in_ready",  128'(ir_a),  128'd1);
        chk("bp release round",     128'(rnd_a), 128'd0);

        // in_valid while busy is ignored.
        @(negedge clk);
        iv_a = 1'b1; id_a = CT_C1;
        @(negedge clk);
        iv_a = 1'b0;
        k = 0;
        while (rnd_a != 4'd3 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("ign reach round 3", 128'(rnd_a), 128'd3);
        chk("ign dp_key slice 3", dpk_a, kb_c1[128*3 +: 128]);
        chk("ign in_ready low", 128'(ir_a), 128'd0);
        iv_a = 1'b1; id_a = CT_B;
        @(negedge clk);
        k++;
        iv_a = 1'b0;
        while (!ov_a && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("ign latency", 128'(k), 128'(NR_A));
        chk("ign plaintext", od_a, PT_REF);
        extra = 0;
        repeat (16) begin
            @(negedge clk);
            if (ov_a) extra++;
        end
        chk("ign no second output", 128'(extra), 128'd0);

        // Reset in the middle of a block.
        @(negedge clk);
        iv_a = 1'b1; id_a = CT_C1;
        @(negedge clk);
        iv_a = 1'b0;
        k = 0;
        while (rnd_a != 4'd5 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("rst reach round 5", 128'(rnd_a), 128'd5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst round",     128'(rnd_a),  128'd0);
        chk("rst out_valid", 128'(ov_a),   128'd0);
        chk("rst busy",      128'(busy_a), 128'd0);
        chk("rst in_ready",  128'(ir_a),   128'd1);
        run_block(1'b0, CT_C1, PT_REF, NR_A, "after_rst");

        // Back-to-back with in_valid held high.
        @(negedge clk);
        iv_a = 1'b1; id_a = CT_C1;
        nacc = 0; nout = 0;
        outs[0] = '0; outs[1] = '0; acc_t[0] = 0; acc_t[1] = 0;
        for (int cyc = 0; cyc < 60 && nout < 2; cyc++) begin
            if (ov_a) begin
                outs[nout] = od_a;
                nout++;
            end
            if (iv_a && ir_a && nacc < 2) begin
                acc_t[nacc] = cyc;
                nacc++;
            end
            @(negedge clk);
        end
        iv_a = 1'b0;
        chk("b2b outputs", 128'(nout), 128'd2);
        chk("b2b accepts", 128'(nacc), 128'd2);
        chk("b2b plaintext 0", outs[0], PT_REF);
        chk("b2b plaintext 1", outs[1], PT_REF);
        chk("b2b accept gap", 128'(acc_t[1] - acc_t[0]), 128'(NR_A + 2));
        @(negedge clk);
        chk("b2b idle after", 128'(busy_a), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
